instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch and sequencing stage that sits directly upstream of the execution engine in the matrix CPU. It holds the program counter and reads 32-bit instruction words from instruction memory over a valid-qualified read port. It latches each word into an instruction register, drives the 5-bit `instr` control field and operand addresses to the execution engine, then waits for the active functional unit to report completion before fetching the next word. The STOP opcode halts sequencing. The unused opcode is skipped and flagged.

## Interface
Parameters:
- `PC_W`, 8, program counter / instruction memory address width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  single-cycle pulse that begins execution from the current `pc`.
- `imem_rd`  out  1  instruction memory read strobe, one cycle per fetch.
- `imem_addr`  out  PC_W  read address; equals `pc`.
- `imem_rdata`  in  32  instruction word; valid when `imem_valid` is high.
- `imem_valid`  in  1  read-data-valid, arriving 1 or more cycles after `imem_rd`.
- `exec_done`  in  1  single-cycle pulse from the functional units when the issued instruction completes.
- `instr`  out  5  IR[31:27] = {opcode[2:0], read_from, write_to_reg} to the execution engine.
- `dst_addr`, `src1_addr`, `src2_addr`  out  8 each  IR[23:16], IR[15:8], IR[7:0].
- `instr_valid`  out  1  one-cycle issue strobe.
- `pc`  out  PC_W  current program counter.
- `halted`  out  1  high in the HALT state.
- `illegal`  out  1  sticky; set when the unused opcode is fetched.

## Operation
- States: IDLE, FETCH, WAIT_MEM, DECODE, ISSUE, WAIT_EXEC, HALT.
- IDLE: `start` moves the FSM to FETCH.
- FETCH: assert `imem_rd` with `imem_addr`=`pc` for exactly one cycle, then go to WAIT_MEM.
- WAIT_MEM: hold until `imem_valid`. Load IR from `imem_rdata`, then go to DECODE.
  - `imem_valid` in any other state is ignored.
- DECODE, by opcode IR[31:29]:
  - 3'b111 (STOP): go to HALT; `pc` is not incremented.
  - 3'b101 (unused): set `illegal`, `pc` <= `pc`+1, go to FETCH. No issue occurs.
  - Any other opcode: go to ISSUE.
- ISSUE: `instr_valid`=1 for one cycle.
  - `exec_done` sampled in this cycle: `pc`+1, go to FETCH.
  - Otherwise go to WAIT_EXEC.
- WAIT_EXEC: on `exec_done`, `pc` <= `pc`+1, go to FETCH.
- HALT: `start` clears `pc` to 0 and goes to FETCH. Only `start` or `reset` leaves HALT.
- `start` in any state other than IDLE or HALT is ignored.
- IR-derived outputs are registered. They change only on an IR load and hold stable otherwise, because the execution engine samples `instr` on every clock.
- `pc` increments modulo 2^PC_W: `pc` = 2^PC_W−1 wraps to 0.
- `illegal` clears only on `reset`.

## Timing
- Reset values:
  - State = IDLE, `pc`=0, IR=32'hA000_0000.
  - `instr`=5'b10100 (unused opcode, so the downstream stage stays idle).
  - Operand addresses = 0.
  - `imem_rd`=0, `instr_valid`=0, `halted`=0, `illegal`=0.
- Reset mid-operation returns to IDLE immediately. An in-flight `imem_valid` after reset is ignored.
- `start` at cycle T gives `imem_rd` at T+1.
- `imem_valid` at cycle V gives the IR load and `instr` update at V+1 (DECODE), and `instr_valid` at V+2.
- Minimum instruction period with 1-cycle memory and `exec_done` in the ISSUE cycle: 4 cycles (FETCH, WAIT_MEM, DECODE, ISSUE).
- `halted` rises the cycle after DECODE of STOP.

## Configuration
- Macro `IFETCH_RETIRE_CNT_EN`.
- When defined, the block adds an output `retired_cnt` [15:0].
  - Reset value 0.
  - Increments on each accepted `exec_done` and saturates at 16'hFFFF.
  - Cleared by `start` from HALT.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

## Structure
- The shared package `cpu_pkg` holds:
  - Opcode constants: ADD=000, SUB=001, SCALE=010, MULT=011, TRANSPOSE=100, UNUSED=101, WRITE_MEM=110, STOP=111.
  - The instruction field bit positions.
  - The fetch state encoding.
  - The execution engine uses the same opcode constants.
- One natural sub-module, `instr_reg`: the 32-bit IR with a load enable and the field-slicing outputs.
- The FSM and PC stay in `instr_fetch`.

## Test plan
- Reset then `start`; memory returns ADD (32'h0003_0201) at pc 0 with 1-cycle latency; `exec_done` 3 cycles after issue.
  - Expect `instr`=5'b00000, dst/src1/src2 = 3/2/1, one `instr_valid` pulse, then `pc`=1 and fetch at address 1.
- Program {SUB, UNUSED, STOP} at addresses 0..2.
  - Expect a SUB issue, no issue for the UNUSED word, `illegal`=1, then `halted`=1 with `pc`=2.
  - Then `start`: `pc`=0, fetch restarts.
- PC_W=2; program of four non-STOP instructions.
  - Expect addresses 0,1,2,3 fetched, then 0 again (wrap).
- Memory latency of 5 cycles with spurious `imem_valid` pulses during WAIT_EXEC.
  - Expect no IR change from the spurious pulses.
  - Expect `instr` stable until the genuine valid.
- Reset asserted during WAIT_MEM, then late `imem_valid`.
  - Expect all outputs at reset values, IR unchanged, and state IDLE.
- With `IFETCH_RETIRE_CNT_EN`: run 3 instructions then STOP.
  - Expect `retired_cnt`=3.
  - Preload the counter to 16'hFFFF and retire one more instruction: expect it to remain at 16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the matrix CPU front end and execution engine.
// Contents:
//   - opcode constants (shared with the execution engine)
//   - instruction word field bit positions
//   - instruction register reset value
//   - fetch FSM state encoding
//   - sat_inc16 : saturating 16-bit increment helper
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes, IR[31:29]
  localparam logic [2:0] OP_ADD       = 3'b000;
  localparam logic [2:0] OP_SUB       = 3'b001;
  localparam logic [2:0] OP_SCALE     = 3'b010;
  localparam logic [2:0] OP_MULT      = 3'b011;
  localparam logic [2:0] OP_TRANSPOSE = 3'b100;
  localparam logic [2:0] OP_UNUSED    = 3'b101;
  localparam logic [2:0] OP_WRITE_MEM = 3'b110;
  localparam logic [2:0] OP_STOP      = 3'b111;

  // Instruction word field positions
  localparam int IR_W          = 32;
  localparam int OPC_HI        = 31;
  localparam int OPC_LO        = 29;
  localparam int READ_FROM_BIT = 28;
  localparam int WR_REG_BIT    = 27;
  localparam int INSTR_HI      = 31;  // instr = {opcode, read_from, write_to_reg}
  localparam int INSTR_LO      = 27;
  localparam int DST_HI        = 23;
  localparam int DST_LO        = 16;
  localparam int SRC1_HI       = 15;
  localparam int SRC1_LO       = 8;
  localparam int SRC2_HI       = 7;
  localparam int SRC2_LO       = 0;

  // Reset IR carries the unused opcode so the execution engine stays idle.
  localparam logic [31:0] IR_RESET_VAL = 32'hA000_0000;

  // Fetch FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_MEM  = 3'd2,
    ST_DECODE    = 3'd3,
    ST_ISSUE     = 3'd4,
    ST_WAIT_EXEC = 3'd5,
    ST_HALT      = 3'd6
  } fetch_state_t;

  // Saturating increment used by the retirement counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/instr_reg.sv
// -----------------------------------------------------------------------------
// instr_reg
// 32-bit instruction register with load enable and field slicing.
// All outputs are direct slices of the register, so they are glitch-free and
// change only on a load; the execution engine samples instr every clock.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   load              load enable for IR
//   load_data [31:0]  word to load
//   opcode    [2:0]   IR[31:29]
//   instr     [4:0]   IR[31:27] = {opcode, read_from, write_to_reg}
//   dst_addr  [7:0]   IR[23:16]
//   src1_addr [7:0]   IR[15:8]
//   src2_addr [7:0]   IR[7:0]
// -----------------------------------------------------------------------------
module instr_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  output logic [2:0]  opcode,
  output logic [4:0]  instr,
  output logic [7:0]  dst_addr,
  output logic [7:0]  src1_addr,
  output logic [7:0]  src2_addr
);

  logic [IR_W-1:0] ir_r;

  // Instruction register: loads only on an accepted memory response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_r <= IR_RESET_VAL;
    end else if (load) begin
      ir_r <= load_data;
    end
  end

  assign opcode    = ir_r[OPC_HI:OPC_LO];
  assign instr     = ir_r[INSTR_HI:INSTR_LO];
  assign dst_addr  = ir_r[DST_HI:DST_LO];
  assign src1_addr = ir_r[SRC1_HI:SRC1_LO];
  assign src2_addr = ir_r[SRC2_HI:SRC2_LO];

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch and sequencing stage ahead of the execution engine.
// Holds the PC, reads one word per instruction over a valid-qualified read
// port, latches it into the IR, issues it and waits for completion.
// STOP halts; the unused opcode is skipped and flagged in the sticky illegal.
//
// Optional feature macro: IFETCH_RETIRE_CNT_EN
//   adds output retired_cnt[15:0], a saturating count of accepted exec_done
//   pulses, cleared by start from HALT.
//
// Parameters:
//   PC_W                 program counter / instruction address width
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start                begin execution (honoured in IDLE and HALT only)
//   imem_rd              one-cycle read strobe per fetch
//   imem_addr [PC_W-1:0] read address (= pc)
//   imem_rdata[31:0]     instruction word, qualified by imem_valid
//   imem_valid           read data valid (accepted only while waiting)
//   exec_done            completion pulse from the functional units
//   instr     [4:0]      {opcode, read_from, write_to_reg}
//   dst_addr/src1_addr/src2_addr [7:0] operand addresses
//   instr_valid          one-cycle issue strobe
//   pc        [PC_W-1:0] program counter
//   halted               high in HALT
//   illegal              sticky unused-opcode flag
//   retired_cnt [15:0]   (IFETCH_RETIRE_CNT_EN only)
// -----------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            exec_done,
  output logic [4:0]      instr,
  output logic [7:0]      dst_addr,
  output logic [7:0]      src1_addr,
  output logic [7:0]      src2_addr,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
`ifdef IFETCH_RETIRE_CNT_EN
  ,
  output logic [15:0]     retired_cnt
`endif
);

  localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};
  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_t    state_r;
  logic [PC_W-1:0] pc_r;
  logic            imem_rd_r;
  logic            instr_valid_r;
  logic            halted_r;
  logic            illegal_r;

  logic            ir_load_s;
  logic [2:0]      ir_opcode_s;
  logic            exec_accept_s;

  // Memory data is only meaningful while a fetch is outstanding.
  assign ir_load_s = (state_r == ST_WAIT_MEM) && imem_valid;

  // exec_done counts only while an issued instruction is outstanding.
  assign exec_accept_s = exec_done &&
                         ((state_r == ST_ISSUE) || (state_r == ST_WAIT_EXEC));

  instr_reg u_instr_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (ir_load_s),
    .load_data (imem_rdata),
    .opcode    (ir_opcode_s),
    .instr     (instr),
    .dst_addr  (dst_addr),
    .src1_addr (src1_addr),
    .src2_addr (src2_addr)
  );

  // Sequencing FSM with PC and registered strobes; imem_rd and instr_valid
  // are set on entry to FETCH / ISSUE so they are high for that one state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= PC_ZERO;
      imem_rd_r     <= 1'b0;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      imem_rd_r     <= 1'b0;
      instr_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_FETCH;
            imem_rd_r <= 1'b1;
          end
        end
        ST_FETCH: begin
          state_r <= ST_WAIT_MEM;
        end
        ST_WAIT_MEM: begin
          if (imem_valid) begin
            state_r <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (ir_opcode_s)
            OP_STOP: begin
              // PC stays on the STOP word for inspection.
              state_r  <= ST_HALT;
              halted_r <= 1'b1;
            end
            OP_UNUSED: begin
              illegal_r <= 1'b1;
              pc_r      <= pc_r + PC_ONE;
              state_r   <= ST_FETCH;
              imem_rd_r <= 1'b1;
            end
            default: begin
              state_r       <= ST_ISSUE;
              instr_valid_r <= 1'b1;
            end
          endcase
        end
        ST_ISSUE: begin
          if (exec_done) begin
            pc_r      <= pc_r + PC_ONE;
            state_r   <= ST_FETCH;
            imem_rd_r <= 1'b1;
          end else begin
            state_r <= ST_WAIT_EXEC;
          end
        end
        ST_WAIT_EXEC: begin
          if (exec_done) begin
            pc_r      <= pc_r + PC_ONE;
            state_r   <= ST_FETCH;
            imem_rd_r <= 1'b1;
          end
        end
        ST_HALT: begin
          if (start) begin
            pc_r      <= PC_ZERO;
            halted_r  <= 1'b0;
            state_r   <= ST_FETCH;
            imem_rd_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_rd     = imem_rd_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr_valid = instr_valid_r;
  assign halted      = halted_r;
  assign illegal     = illegal_r;

`ifdef IFETCH_RETIRE_CNT_EN
  logic [15:0] retired_cnt_r;

  // Retirement counter: saturating, restarted with the program from HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt_r <= 16'h0000;
    end else if ((state_r == ST_HALT) && start) begin
      retired_cnt_r <= 16'h0000;
    end else if (exec_accept_s) begin
      retired_cnt_r <= sat_inc16(retired_cnt_r);
    end
  end

  assign retired_cnt = retired_cnt_r;
`else
  // Keeps the completion qualifier referenced when no counter is built.
  logic exec_accept_unused_s;
  assign exec_accept_unused_s = exec_accept_s;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch: a table of instruction vectors is run
// through a handshake driver, expected issue fields go into a scoreboard queue
// and are compared when instr_valid fires. Hand-written sequences cover
// UNUSED/STOP, restart, spurious valids, long latency and mid-fetch reset.
// A second instance with PC_W=2 free-runs to check PC wrap.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        exec_done;
  logic [4:0]  instr;
  logic [7:0]  dst_addr, src1_addr, src2_addr;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;
  logic        illegal;
`ifdef IFETCH_RETIRE_CNT_EN
  logic [15:0] retired_cnt;
  logic [15:0] retired_cnt2;
`endif

  instr_fetch #(.PC_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .exec_done(exec_done),
    .instr(instr), .dst_addr(dst_addr), .src1_addr(src1_addr),
    .src2_addr(src2_addr), .instr_valid(instr_valid), .pc(pc),
    .halted(halted), .illegal(illegal)
`ifdef IFETCH_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  // Second instance: PC_W=2, 1-cycle memory, exec_done in the ISSUE cycle.
  logic        reset2, start2, rd2, valid2, iv2, halted2, illegal2;
  logic [1:0]  addr2, pc2;
  logic [4:0]  instr2;
  logic [7:0]  dst2, s1_2, s2_2;
  logic [31:0] rdata2;
  logic [1:0]  addr2_q[$];

  assign rdata2 = 32'h0003_0201;

  instr_fetch #(.PC_W(2)) dut2 (
    .clk(clk), .reset(reset2), .start(start2),
    .imem_rd(rd2), .imem_addr(addr2), .imem_rdata(rdata2),
    .imem_valid(valid2), .exec_done(iv2),
    .instr(instr2), .dst_addr(dst2), .src1_addr(s1_2),
    .src2_addr(s2_2), .instr_valid(iv2), .pc(pc2),
    .halted(halted2), .illegal(illegal2)
`ifdef IFETCH_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt2)
`endif
  );

  // Memory model for dut2: data valid one cycle after the read strobe.
  always @(posedge clk) valid2 <= rd2;

  // Record every address dut2 fetches.
  always @(negedge clk) if (rd2 === 1'b1) addr2_q.push_back(addr2);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected issue fields
  typedef struct {
    logic [4:0] instr;
    logic [7:0] dst, src1, src2;
  } exp_t;
  exp_t sb_q[$];

  // Issue monitor: every instr_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got instr %0h with no pending instruction", instr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("issue_instr", {27'd0, instr}, {27'd0, e.instr});
        chk("issue_dst", {24'd0, dst_addr}, {24'd0, e.dst});
        chk("issue_src1", {24'd0, src1_addr}, {24'd0, e.src1});
        chk("issue_src2", {24'd0, src2_addr}, {24'd0, e.src2});
      end
    end
  end

  typedef struct {
    logic [31:0] word;
    int          mem_lat;
    int          exec_lat;
    logic [4:0]  exp_instr;
    logic [7:0]  exp_dst, exp_src1, exp_src2;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd();
    int n = 0;
    while (imem_rd !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("fetch_seen", {31'd0, imem_rd}, 32'd1);
  endtask

  // One issuable instruction: fetch, respond after mem_lat, complete after exec_lat.
  task automatic run_instr(input logic [31:0] word, input int mem_lat, input int exec_lat,
                           input logic [7:0] exp_pc, input logic [4:0] ei,
                           input logic [7:0] ed, input logic [7:0] es1, input logic [7:0] es2,
                           input bit spurious, input logic [4:0] prev_instr);
    exp_t e;
    wait_rd();
    chk("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
    tick();
    chk("rd_one_cycle", {31'd0, imem_rd}, 32'd0);
    for (int k = 1; k < mem_lat; k++) begin
      chk("instr_hold_mem", {27'd0, instr}, {27'd0, prev_instr});
      tick();
    end
    chk("instr_before_valid", {27'd0, instr}, {27'd0, prev_instr});
    imem_valid = 1'b1;
    imem_rdata = word;
    e.instr = ei; e.dst = ed; e.src1 = es1; e.src2 = es2;
    sb_q.push_back(e);
    tick();
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("decode_instr", {27'd0, instr}, {27'd0, ei});
    chk("decode_no_issue", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("issue_strobe", {31'd0, instr_valid}, 32'd1);
    for (int k = 1; k <= exec_lat; k++) begin
      if (spurious && k == 1) begin
        imem_valid = 1'b1;
        imem_rdata = 32'h7FFF_FFFF;
      end
      tick();
      imem_valid = 1'b0;
      chk("instr_hold_exec", {27'd0, instr}, {27'd0, ei});
      chk("issue_single", {31'd0, instr_valid}, 32'd0);
    end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("next_fetch_rd", {31'd0, imem_rd}, 32'd1);
    chk("next_fetch_pc", {24'd0, pc}, {24'd0, exp_pc + 8'd1});
  endtask

  task automatic run_unused(input logic [31:0] word, input logic [7:0] exp_pc);
    wait_rd();
    chk("unused_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
    tick();
    imem_valid = 1'b1;
    imem_rdata = word;
    tick();
    imem_valid = 1'b0;
    chk("unused_decode_noissue", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("unused_skip_rd", {31'd0, imem_rd}, 32'd1);
    chk("unused_pc", {24'd0, pc}, {24'd0, exp_pc + 8'd1});
    chk("unused_illegal", {31'd0, illegal}, 32'd1);
    chk("unused_noissue", {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic run_stop(input logic [7:0] exp_pc);
    wait_rd();
    chk("stop_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
    tick();
    imem_valid = 1'b1;
    imem_rdata = 32'hE000_0000;
    tick();
    imem_valid = 1'b0;
    chk("stop_decode_not_halted", {31'd0, halted}, 32'd0);
    tick();
    chk("stop_halted", {31'd0, halted}, 32'd1);
    chk("stop_pc", {24'd0, pc}, {24'd0, exp_pc});
    chk("stop_noissue", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("halt_no_fetch", {31'd0, imem_rd}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_instr"}, {27'd0, instr}, 32'h14);
    chk({tag, "_dst"}, {24'd0, dst_addr}, 32'd0);
    chk({tag, "_src1"}, {24'd0, src1_addr}, 32'd0);
    chk({tag, "_src2"}, {24'd0, src2_addr}, 32'd0);
    chk({tag, "_pc"}, {24'd0, pc}, 32'd0);
    chk({tag, "_rd"}, {31'd0, imem_rd}, 32'd0);
    chk({tag, "_iv"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    logic [4:0] prev;
    vecs[0] = '{32'h2812_3456, 1, 0, 5'b00101, 8'h12, 8'h34, 8'h56};
    vecs[1] = '{32'h58AA_BBCC, 2, 1, 5'b01011, 8'hAA, 8'hBB, 8'hCC};
    vecs[2] = '{32'h6001_0203, 1, 2, 5'b01100, 8'h01, 8'h02, 8'h03};
    vecs[3] = '{32'h90FF_0011, 3, 0, 5'b10010, 8'hFF, 8'h00, 8'h11};
    vecs[4] = '{32'hC87F_8001, 1, 1, 5'b11001, 8'h7F, 8'h80, 8'h01};
    vecs[5] = '{32'h0703_0201, 2, 0, 5'b00000, 8'h03, 8'h02, 8'h01};

    reset = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
    exec_done = 1'b0; reset2 = 1'b1; start2 = 1'b0;
    tick(); tick();
    chk_reset_outputs("rst");
    reset = 1'b0; reset2 = 1'b0;
    tick();
    chk("idle_no_fetch", {31'd0, imem_rd}, 32'd0);
    start2 = 1'b1;

    // ADD at pc 0, exec_done 3 cycles after issue
    start = 1'b1;
    tick();
    start = 1'b0; start2 = 1'b0;
    chk("start_to_rd", {31'd0, imem_rd}, 32'd1);
    run_instr(32'h0003_0201, 1, 3, 8'd0, 5'b00000, 8'h03, 8'h02, 8'h01, 1'b0, 5'b10100);

    // Table of opcodes, latencies and field patterns
    prev = 5'b00000;
    for (int i = 0; i < 6; i++) begin
      run_instr(vecs[i].word, vecs[i].mem_lat, vecs[i].exec_lat, 8'(i + 1),
                vecs[i].exp_instr, vecs[i].exp_dst, vecs[i].exp_src1, vecs[i].exp_src2,
                1'b0, prev);
      prev = vecs[i].exp_instr;
    end
    run_stop(8'd7);
    chk("no_illegal_yet", {31'd0, illegal}, 32'd0);
`ifdef IFETCH_RETIRE_CNT_EN
    chk("retired_7", {16'd0, retired_cnt}, 32'd7);
`endif

    // Restart from HALT, then SUB / UNUSED / STOP
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_pc", {24'd0, pc}, 32'd0);
    chk("restart_rd", {31'd0, imem_rd}, 32'd1);
    chk("restart_halted", {31'd0, halted}, 32'd0);
`ifdef IFETCH_RETIRE_CNT_EN
    chk("retired_cleared", {16'd0, retired_cnt}, 32'd0);
`endif
    run_instr(32'h2812_3456, 1, 1, 8'd0, 5'b00101, 8'h12, 8'h34, 8'h56, 1'b0, 5'b11100);
    run_unused(32'hA512_3456, 8'd1);
    run_stop(8'd2);
    chk("illegal_sticky_halt", {31'd0, illegal}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart2_pc", {24'd0, pc}, 32'd0);
    chk("restart2_rd", {31'd0, imem_rd}, 32'd1);
    chk("illegal_sticky_start", {31'd0, illegal}, 32'd1);

    // 5-cycle memory, spurious valids during WAIT_EXEC
    run_instr(32'h1803_0201, 5, 3, 8'd0, 5'b00011, 8'h03, 8'h02, 8'h01, 1'b1, 5'b11100);
    run_instr(32'h58AA_BBCC, 5, 2, 8'd1, 5'b01011, 8'hAA, 8'hBB, 8'hCC, 1'b1, 5'b00011);

    // start outside IDLE/HALT is ignored: pulse it in WAIT_MEM
    wait_rd();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_rd", {31'd0, imem_rd}, 32'd0);
    chk("start_ignored_pc", {24'd0, pc}, 32'd2);

    // Reset during WAIT_MEM, then a late imem_valid
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    tick();
    reset = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'h0003_0201;
    tick();
    imem_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_valid_instr", {27'd0, instr}, 32'h14);
      chk("late_valid_idle_rd", {31'd0, imem_rd}, 32'd0);
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_start_rd", {31'd0, imem_rd}, 32'd1);
    chk("post_rst_pc", {24'd0, pc}, 32'd0);

`ifdef IFETCH_RETIRE_CNT_EN
    // Three instructions then STOP, then saturation from a preloaded count
    run_instr(32'h0003_0201, 1, 0, 8'd0, 5'b00000, 8'h03, 8'h02, 8'h01, 1'b0, 5'b10100);
    run_instr(32'h2812_3456, 1, 1, 8'd1, 5'b00101, 8'h12, 8'h34, 8'h56, 1'b0, 5'b00000);
    run_instr(32'h6001_0203, 2, 0, 8'd2, 5'b01100, 8'h01, 8'h02, 8'h03, 1'b0, 5'b00101);
    run_stop(8'd3);
    chk("retired_3", {16'd0, retired_cnt}, 32'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    dut.retired_cnt_r = 16'hFFFF;
    run_instr(32'h0003_0201, 1, 0, 8'd0, 5'b00000, 8'h03, 8'h02, 8'h01, 1'b0, 5'b11100);
    chk("retired_saturate", {16'd0, retired_cnt}, 32'h0000_FFFF);
`endif

    // PC_W=2 wrap on the second instance
    chk("wrap_count", (addr2_q.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    if (addr2_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("wrap_addr", {30'd0, addr2_q[i]}, 32'(i % 4));
      end
    end

    tick(); tick();
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in 200000 time units");
    $fatal(1);
  end

endmodule
